idma_nd3_midend: RTL and testbench
==================================

// Module: idma_nd3_midend
// PURPOSE
// - Downstream of the 32-bit 3D register front-end: accepts one ND job (base 1D burst + 2 outer dims), emits a sequence of 1D bursts to the backend.
// - Tracks backend completions and returns one done handshake per ND job.
// - Drives a busy flag that feeds the front-end's midend_busy_i status field.
// PARAMETERS
// - AddrWidth      32  address / stride width
// - LenWidth       32  1D burst length width (bytes)
// - RepWidth       32  repetition count width per dimension
// - MaxOutstanding 8   max issued-but-unacknowledged bursts (>=1)
// PORTS
// - clk_i            in   1          clock
// - rst_ni           in   1          async reset, active-low
// - nd_valid_i       in   1          ND job valid
// - nd_ready_o       out  1          ND job accepted
// - nd_len_i         in   LenWidth   per-burst length
// - nd_src_i         in   AddrWidth  source base
// - nd_dst_i         in   AddrWidth  destination base
// - nd_reps_i        in   2*RepWidth [RepWidth-1:0]=dim0 reps, upper half=dim1 reps
// - nd_src_str_i     in   2*AddrWidth src strides dim0 | dim1 (same packing)
// - nd_dst_str_i     in   2*AddrWidth dst strides dim0 | dim1
// - burst_valid_o    out  1          1D burst valid
// - burst_ready_i    in   1          backend accepts burst
// - burst_len_o      out  LenWidth   burst length
// - burst_src_o      out  AddrWidth  burst source address
// - burst_dst_o      out  AddrWidth  burst destination address
// - burst_done_i     in   1          one backend completion (single-cycle pulse)
// - nd_done_valid_o  out  1          ND job complete
// - nd_done_ready_i  in   1          completion consumed
// - busy_o           out  1          job in flight (state != IDLE)
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0 except nd_ready_o=1; counters and registers cleared.
// - States: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
// - IDLE: nd_ready_o=1; on nd_valid_i, register all fields and go to ISSUE (burst_valid_o rises next cycle).
// - A reps value of 0 is treated as 1; total bursts = R0*R1.
// - Issue order: i0 inner, i1 outer.
//   - addr = base + i0*s0 + i1*s1, computed incrementally: add s0 per burst; on i0 wrap, add s1 to the row base and reload.
//   - All sums are modulo 2^AddrWidth (wrap, no error).
// - ISSUE: burst_valid_o=1 while outstanding<MaxOutstanding; payload stable while valid & !ready.
//   - At outstanding==MaxOutstanding, deassert valid and resume next cycle after a done (no same-cycle bypass).
//   - On handshake of the last burst (i0=R0-1, i1=R1-1), go to DRAIN.
// - Outstanding counter ($clog2(MaxOutstanding+1) bits):
//   - +1 on a burst handshake, -1 on burst_done_i; simultaneous = no change.
//   - burst_done_i while outstanding==0 is ignored (no underflow).
// - DRAIN: when outstanding==0 (including the combined handshake+done cycle), go to DONE.
// - DONE: nd_done_valid_o=1, held until nd_done_ready_i; then IDLE.
//   - nd_ready_o is 0 in every state except IDLE, so there is no back-to-back accept in the done cycle.
// - Latency: minimum accept -> first burst_valid_o = 1 cycle; last done -> nd_done_valid_o = 1 cycle.
// - Reset mid-job: job discarded; late burst_done_i after reset is ignored (outstanding stays 0).
// CONFIGURATION
// - IDMA_ND_ZERO_LEN_SKIP_EN defined: nd_len_i==0 jobs go IDLE->DONE directly with no bursts; done valid 1 cycle after accept.
// - Macro undefined: zero-length jobs issue all R0*R1 bursts with len 0 like any other job.
// TESTING
// - len=64, src=0x1000, dst=0x8000, reps={0,0} -> one burst (64, 0x1000, 0x8000); done after one burst_done_i.
// - reps dim0=3, dim1=2, s0=0x100/0x40, s1=0x1000/0x400, src=0, dst=0 -> src 0,0x100,0x200,0x1000,0x1100,0x1200; dst 0,0x40,0x80,0x400,0x440,0x480.
// - MaxOutstanding=2, reps0=5, burst_done_i withheld -> exactly 2 handshakes, valid low; each done releases one more burst.
// - burst_ready_i low 4 cycles with random payload check -> fields stable; simultaneous handshake+done keeps outstanding constant.
// - src=0xFFFF_FFF0, s0=0x20, reps0=2 -> second src = 0x0000_0010; reset asserted in DRAIN -> IDLE, nd_ready_o=1, no done.
// - len=0, reps0=4: with macro -> 0 bursts, done 1 cycle after accept; without -> 4 zero-length bursts, then done.

Source files
------------

// File: rtl/idma_nd3_midend.sv
// idma_nd3_midend: expands one 3D job (a base 1D burst plus two outer
// repetition dimensions) into a stream of 1D bursts for the backend. It counts
// the bursts the backend has not yet completed and returns one done handshake
// per job.
// Optional feature macro: IDMA_ND_ZERO_LEN_SKIP_EN. When it is defined,
// zero-length jobs complete without issuing any burst.
module idma_nd3_midend #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned LenWidth       = 32,
  parameter int unsigned RepWidth       = 32,
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   nd_valid_i,
  output logic                   nd_ready_o,
  input  logic [LenWidth-1:0]    nd_len_i,
  input  logic [AddrWidth-1:0]   nd_src_i,
  input  logic [AddrWidth-1:0]   nd_dst_i,
  input  logic [2*RepWidth-1:0]  nd_reps_i,
  input  logic [2*AddrWidth-1:0] nd_src_str_i,
  input  logic [2*AddrWidth-1:0] nd_dst_str_i,
  output logic                   burst_valid_o,
  input  logic                   burst_ready_i,
  output logic [LenWidth-1:0]    burst_len_o,
  output logic [AddrWidth-1:0]   burst_src_o,
  output logic [AddrWidth-1:0]   burst_dst_o,
  input  logic                   burst_done_i,
  output logic                   nd_done_valid_o,
  input  logic                   nd_done_ready_i,
  output logic                   busy_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);
  localparam logic [RepWidth-1:0] RepOne = RepWidth'(1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [LenWidth-1:0]    len_q, len_d;
  logic [AddrWidth-1:0]   src_row_q, src_row_d, dst_row_q, dst_row_d;
  logic [AddrWidth-1:0]   src_cur_q, src_cur_d, dst_cur_q, dst_cur_d;
  logic [AddrWidth-1:0]   src_s0_q, src_s0_d, src_s1_q, src_s1_d;
  logic [AddrWidth-1:0]   dst_s0_q, dst_s0_d, dst_s1_q, dst_s1_d;
  logic [RepWidth-1:0]    r0_q, r0_d, r1_q, r1_d, i0_q, i0_d, i1_q, i1_d;
  logic [CntWidth-1:0]    out_q, out_d;
  logic                   burst_hs_s, done_take_s, i0_wrap_s, last_s;
  logic [RepWidth-1:0]    reps0_s, reps1_s;

  // All outputs are decoded directly from registered state.
  assign nd_ready_o      = (state_q == StIdle);
  assign busy_o          = (state_q != StIdle);
  assign nd_done_valid_o = (state_q == StDone);
  assign burst_valid_o   = (state_q == StIssue) && (out_q < MaxCnt);
  assign burst_len_o     = len_q;
  assign burst_src_o     = src_cur_q;
  assign burst_dst_o     = dst_cur_q;

  assign burst_hs_s  = burst_valid_o && burst_ready_i;
  // A completion with nothing outstanding is stale (e.g. from before a reset).
  assign done_take_s = burst_done_i && (out_q != {CntWidth{1'b0}});
  assign i0_wrap_s   = (i0_q == (r0_q - RepOne));
  assign last_s      = i0_wrap_s && (i1_q == (r1_q - RepOne));
  // A repetition count of zero means one pass through that dimension.
  assign reps0_s = (nd_reps_i[RepWidth-1:0] == {RepWidth{1'b0}}) ?
                   RepOne : nd_reps_i[RepWidth-1:0];
  assign reps1_s = (nd_reps_i[2*RepWidth-1:RepWidth] == {RepWidth{1'b0}}) ?
                   RepOne : nd_reps_i[2*RepWidth-1:RepWidth];

  // Outstanding-burst counter: a handshake and a completion in the same cycle cancel.
  always_comb begin
    out_d = out_q;
    if (burst_hs_s && !done_take_s) begin
      out_d = out_q + CntOne;
    end else if (!burst_hs_s && done_take_s) begin
      out_d = out_q - CntOne;
    end else begin
      out_d = out_q;
    end
  end

  // Job sequencing and incremental address generation (dim0 inner, dim1 outer).
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    src_row_d = src_row_q;
    dst_row_d = dst_row_q;
    src_cur_d = src_cur_q;
    dst_cur_d = dst_cur_q;
    src_s0_d  = src_s0_q;
    src_s1_d  = src_s1_q;
    dst_s0_d  = dst_s0_q;
    dst_s1_d  = dst_s1_q;
    r0_d      = r0_q;
    r1_d      = r1_q;
    i0_d      = i0_q;
    i1_d      = i1_q;
    case (state_q)
      StIdle: begin
        if (nd_valid_i) begin
          len_d     = nd_len_i;
          src_row_d = nd_src_i;
          dst_row_d = nd_dst_i;
          src_cur_d = nd_src_i;
          dst_cur_d = nd_dst_i;
          src_s0_d  = nd_src_str_i[AddrWidth-1:0];
          src_s1_d  = nd_src_str_i[2*AddrWidth-1:AddrWidth];
          dst_s0_d  = nd_dst_str_i[AddrWidth-1:0];
          dst_s1_d  = nd_dst_str_i[2*AddrWidth-1:AddrWidth];
          r0_d      = reps0_s;
          r1_d      = reps1_s;
          i0_d      = {RepWidth{1'b0}};
          i1_d      = {RepWidth{1'b0}};
`ifdef IDMA_ND_ZERO_LEN_SKIP_EN
          if (nd_len_i == {LenWidth{1'b0}}) begin
            state_d = StDone;
          end else begin
            state_d = StIssue;
          end
`else
          state_d = StIssue;
`endif
        end else begin
          state_d = StIdle;
        end
      end
      StIssue: begin
        if (burst_hs_s) begin
          if (i0_wrap_s) begin
            i0_d = {RepWidth{1'b0}};
            if (last_s) begin
              state_d = StDrain;
            end else begin
              // Advance to the next row and restart the inner dimension there.
              i1_d      = i1_q + RepOne;
              src_row_d = src_row_q + src_s1_q;
              dst_row_d = dst_row_q + dst_s1_q;
              src_cur_d = src_row_q + src_s1_q;
              dst_cur_d = dst_row_q + dst_s1_q;
            end
          end else begin
            i0_d      = i0_q + RepOne;
            src_cur_d = src_cur_q + src_s0_q;
            dst_cur_d = dst_cur_q + dst_s0_q;
          end
        end else begin
          state_d = StIssue;
        end
      end
      StDrain: begin
        if (out_d == {CntWidth{1'b0}}) begin
          state_d = StDone;
        end else begin
          state_d = StDrain;
        end
      end
      StDone: begin
        if (nd_done_ready_i) begin
          state_d = StIdle;
        end else begin
          state_d = StDone;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, job fields and counters; reset discards any job in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      len_q     <= {LenWidth{1'b0}};
      src_row_q <= {AddrWidth{1'b0}};
      dst_row_q <= {AddrWidth{1'b0}};
      src_cur_q <= {AddrWidth{1'b0}};
      dst_cur_q <= {AddrWidth{1'b0}};
      src_s0_q  <= {AddrWidth{1'b0}};
      src_s1_q  <= {AddrWidth{1'b0}};
      dst_s0_q  <= {AddrWidth{1'b0}};
      dst_s1_q  <= {AddrWidth{1'b0}};
      r0_q      <= {RepWidth{1'b0}};
      r1_q      <= {RepWidth{1'b0}};
      i0_q      <= {RepWidth{1'b0}};
      i1_q      <= {RepWidth{1'b0}};
      out_q     <= {CntWidth{1'b0}};
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      src_row_q <= src_row_d;
      dst_row_q <= dst_row_d;
      src_cur_q <= src_cur_d;
      dst_cur_q <= dst_cur_d;
      src_s0_q  <= src_s0_d;
      src_s1_q  <= src_s1_d;
      dst_s0_q  <= dst_s0_d;
      dst_s1_q  <= dst_s1_d;
      r0_q      <= r0_d;
      r1_q      <= r1_d;
      i0_q      <= i0_d;
      i1_q      <= i1_d;
      out_q     <= out_d;
    end
  end

endmodule

// File: tb/tb_idma_nd3_midend.sv
// Scoreboard bench for idma_nd3_midend (instantiated with MaxOutstanding=2).
module tb_idma_nd3_midend;

  localparam int MAXO = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        nd_valid_i, nd_ready_o;
  logic [31:0] nd_len_i, nd_src_i, nd_dst_i;
  logic [63:0] nd_reps_i, nd_src_str_i, nd_dst_str_i;
  logic        burst_valid_o, burst_ready_i;
  logic [31:0] burst_len_o, burst_src_o, burst_dst_o;
  logic        burst_done_i, nd_done_valid_o, nd_done_ready_i, busy_o;

  typedef struct packed {
    logic [31:0] len;
    logic [31:0] src;
    logic [31:0] dst;
  } burst_t;

  burst_t exp_q[$];
  int     errors = 0;
  int     checks = 0;
  int     pend = 0;
  int     hs_total = 0;
  int     jobs_done = 0;
  int     jobs_exp = 0;
  bit     job_active = 1'b0;
  bit     done_pend = 1'b0;
  bit     have_prev = 1'b0;
  burst_t prev_b;
  bit     hold_done = 1'b0;
  bit     force_done = 1'b0;
  int     ready_mode = 1;
`ifdef IDMA_ND_ZERO_LEN_SKIP_EN
  bit     skip_zero = 1'b1;
`else
  bit     skip_zero = 1'b0;
`endif

  idma_nd3_midend #(
    .AddrWidth(32), .LenWidth(32), .RepWidth(32), .MaxOutstanding(MAXO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .nd_valid_i(nd_valid_i), .nd_ready_o(nd_ready_o),
    .nd_len_i(nd_len_i), .nd_src_i(nd_src_i), .nd_dst_i(nd_dst_i),
    .nd_reps_i(nd_reps_i), .nd_src_str_i(nd_src_str_i), .nd_dst_str_i(nd_dst_str_i),
    .burst_valid_o(burst_valid_o), .burst_ready_i(burst_ready_i),
    .burst_len_o(burst_len_o), .burst_src_o(burst_src_o), .burst_dst_o(burst_dst_o),
    .burst_done_i(burst_done_i),
    .nd_done_valid_o(nd_done_valid_o), .nd_done_ready_i(nd_done_ready_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the full list of bursts of a job, by plain arithmetic.
  task automatic run_job(input logic [31:0] len, input logic [31:0] src, input logic [31:0] dst,
                         input logic [31:0] reps0, input logic [31:0] reps1,
                         input logic [31:0] ss0, input logic [31:0] ss1,
                         input logic [31:0] ds0, input logic [31:0] ds1);
    logic [31:0] r0, r1;
    burst_t      b;
    int          n;
    r0 = (reps0 == 32'd0) ? 32'd1 : reps0;
    r1 = (reps1 == 32'd0) ? 32'd1 : reps1;
    if (!(skip_zero && len == 32'd0)) begin
      for (logic [31:0] i1 = 32'd0; i1 < r1; i1++) begin
        for (logic [31:0] i0 = 32'd0; i0 < r0; i0++) begin
          b.len = len;
          b.src = src + i0 * ss0 + i1 * ss1;
          b.dst = dst + i0 * ds0 + i1 * ds1;
          exp_q.push_back(b);
        end
      end
    end
    jobs_exp++;
    @(posedge clk_i); #1;
    nd_len_i = len; nd_src_i = src; nd_dst_i = dst;
    nd_reps_i = {reps1, reps0};
    nd_src_str_i = {ss1, ss0};
    nd_dst_str_i = {ds1, ds0};
    nd_valid_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!nd_ready_o && n < 50);
    @(posedge clk_i); #1;
    nd_valid_i = 1'b0;
    nd_len_i = $urandom; nd_src_i = $urandom; nd_dst_i = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((job_active || done_pend || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    chk("wait_idle_in_time", (n < 3000), 1'b1);
  endtask

  // Backend model: random ready, completions only for accepted bursts.
  initial begin
    burst_ready_i = 1'b0; burst_done_i = 1'b0; nd_done_ready_i = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      case (ready_mode)
        0: burst_ready_i = 1'($urandom_range(0, 1));
        1: burst_ready_i = 1'b1;
        default: burst_ready_i = 1'b0;
      endcase
      burst_done_i = force_done || (!hold_done && pend > 0 && $urandom_range(0, 2) == 0);
      nd_done_ready_i = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: checks what the DUT presents now, then predicts the next edge.
  initial begin
    forever begin
      bit     hs, acc, dhs, exp_v;
      int     pend_n;
      burst_t cur, e;
      @(negedge clk_i);
      if (!rst_ni) begin
        exp_q.delete();
        pend = 0; job_active = 1'b0; done_pend = 1'b0; have_prev = 1'b0;
      end else begin
        cur = '{len: burst_len_o, src: burst_src_o, dst: burst_dst_o};
        chk("busy", busy_o, job_active);
        chk("nd_ready", nd_ready_o, !job_active);
        chk("nd_done_valid", nd_done_valid_o, done_pend);
        exp_v = job_active && !done_pend && exp_q.size() > 0 && pend < MAXO;
        chk("burst_valid", burst_valid_o, exp_v);
        if (have_prev && burst_valid_o) chk("payload_stable", cur, prev_b);
        hs = burst_valid_o && burst_ready_i;
        if (hs) begin
          hs_total++;
          if (exp_q.size() == 0) begin
            chk("burst_unexpected", cur, 96'd0);
          end else begin
            e = exp_q.pop_front();
            chk("burst_payload", cur, e);
          end
        end
        have_prev = burst_valid_o && !burst_ready_i;
        prev_b = cur;
        pend_n = pend + (hs ? 1 : 0) - ((burst_done_i && pend > 0) ? 1 : 0);
        acc = nd_valid_i && nd_ready_o;
        dhs = nd_done_valid_o && nd_done_ready_i;
        if (dhs) begin
          job_active = 1'b0;
          done_pend = 1'b0;
          jobs_done++;
        end else begin
          if (acc) job_active = 1'b1;
          if (job_active && !done_pend && exp_q.size() == 0 && pend_n == 0) done_pend = 1'b1;
        end
        pend = pend_n;
      end
    end
  end

  initial begin
    int h0, n;
    nd_valid_i = 1'b0; nd_len_i = '0; nd_src_i = '0; nd_dst_i = '0;
    nd_reps_i = '0; nd_src_str_i = '0; nd_dst_str_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_nd_ready", nd_ready_o, 1'b1);
    chk("rst_burst_valid", burst_valid_o, 1'b0);
    chk("rst_done_valid", nd_done_valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_payload", {burst_len_o, burst_src_o, burst_dst_o}, 96'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1;

    // Single burst from zero reps, then the 3x2 strided pattern.
    run_job(32'd64, 32'h1000, 32'h8000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    wait_idle();
    run_job(32'd64, 32'd0, 32'd0, 32'd3, 32'd2, 32'h100, 32'h1000, 32'h40, 32'h400);
    wait_idle();

    // Completions withheld: only MAXO bursts may be in flight.
    @(negedge clk_i); hold_done = 1'b1; ready_mode = 1; h0 = hs_total;
    run_job(32'd16, 32'h2000, 32'h3000, 32'd5, 32'd1, 32'h10, 32'd0, 32'h10, 32'd0);
    repeat (10) @(negedge clk_i);
    chk("maxout_handshakes", 32'(hs_total - h0), 32'd2);
    hold_done = 1'b0;
    wait_idle();
    chk("maxout_total", 32'(hs_total - h0), 32'd5);

    // Backend stalls for 4 cycles on a random job.
    @(negedge clk_i); ready_mode = 2;
    run_job($urandom, $urandom, $urandom, 32'd3, 32'd2, $urandom, $urandom, $urandom, $urandom);
    repeat (4) @(negedge clk_i);
    ready_mode = 0;
    wait_idle();

    // Address wrap modulo 2^32.
    run_job(32'd32, 32'hFFFF_FFF0, 32'h0, 32'd2, 32'd1, 32'h20, 32'd0, 32'h8, 32'd0);
    wait_idle();

    // Reset while draining: job discarded, late completion ignored.
    @(negedge clk_i); hold_done = 1'b1; ready_mode = 1;
    run_job(32'd8, 32'h40, 32'h80, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0);
    n = 0;
    while (!(job_active && exp_q.size() == 0 && pend == 1) && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk("reached_drain", (n < 100), 1'b1);
    @(posedge clk_i); #1 rst_ni = 1'b0;
    jobs_exp--;
    @(negedge clk_i);
    chk("midrst_nd_ready", nd_ready_o, 1'b1);
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_done_valid", nd_done_valid_o, 1'b0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(negedge clk_i); hold_done = 1'b0; force_done = 1'b1;
    @(negedge clk_i); force_done = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("late_done_no_done", nd_done_valid_o, 1'b0);
    chk("late_done_idle", nd_ready_o, 1'b1);

    // Zero-length job.
    @(negedge clk_i); ready_mode = 0; h0 = hs_total;
    run_job(32'd0, 32'h100, 32'h200, 32'd4, 32'd1, 32'h4, 32'd0, 32'h4, 32'd0);
    wait_idle();
    chk("zero_len_bursts", 32'(hs_total - h0), skip_zero ? 32'd0 : 32'd4);

    // Random jobs.
    for (int k = 0; k < 20; k++) begin
      run_job(($urandom_range(0, 4) == 0) ? 32'd0 : $urandom, $urandom, $urandom,
              32'($urandom_range(0, 4)), 32'($urandom_range(0, 3)),
              $urandom, $urandom, $urandom, $urandom);
      wait_idle();
    end
    repeat (3) @(negedge clk_i);
    chk("jobs_completed", 32'(jobs_done), 32'(jobs_exp));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
